lsu: RTL
========

Name: lsu

Overview:
- Load/store unit directly downstream of the execute-stage ALU in the xiao-rv core.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs a valid/grant/rvalid transaction on the data-memory bus, with byte-lane steering and load sign/zero extension.
- Holds `stall` high while busy so the core freezes PC and register writeback until the access finishes.

Parameters:
- DW, 32, data width; only 32 is supported.
- AW, 32, address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  current instruction is a load/store
- req_we  in  1  1=store, 0=load
- req_size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  AW  effective address (ALU result)
- wdata  in  DW  store data (rs2)
- stall  out  1  core must hold the current instruction
- done  out  1  one-cycle completion pulse
- rdata  out  DW  extended load result, valid while done=1
- misaligned  out  1  misaligned-access flag, valid while done=1
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  AW  word-aligned address, {addr[AW-1:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  DW  lane-steered store data
- mem_gnt  in  1  bus accepted the request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registered outputs are 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, done, misaligned.
  - stall=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid: capture we, size, addr and steered wdata/be.
    - Legal and aligned: go to REQ.
    - Illegal size (011/110/111, or 1xx for a store) or misaligned: go to DONE with no bus access.
- REQ:
  - mem_req=1; mem_we/mem_addr/mem_be/mem_wdata are held stable until granted.
  - mem_gnt=1 on the first REQ cycle is legal (zero wait states).
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - stall=1.
- WAIT:
  - mem_req=0, stall=1.
  - On mem_rvalid: latch the extracted load data into rdata, then go to DONE.
  - mem_rvalid in any state other than WAIT is ignored.
- DONE:
  - done=1, stall=0; the core commits this cycle.
  - req_valid is ignored here (it still belongs to the same instruction).
  - Always returns to IDLE.
- Minimum latency, counted from the IDLE accept cycle to the DONE cycle:
  - Store: 2 cycles.
  - Load: 3 cycles (gnt in first REQ cycle, rvalid in first WAIT cycle).
- Store lane steering (o = addr[1:0]):
  - SB: be = 4'b0001<<o; mem_wdata = wdata[7:0] replicated ×4.
  - SH: be = o[1] ? 1100 : 0011; mem_wdata = wdata[15:0] replicated ×2.
  - SW: be = 1111; mem_wdata = wdata.
- Load extraction:
  - B/BU: byte = mem_rdata[8*o +: 8], sign- or zero-extended.
  - H/HU: half = mem_rdata[16*o[1] +: 16], sign- or zero-extended.
  - W: mem_rdata passed through.
  - For stores and no-access completions, rdata=0.
- Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
- rst_n asserted mid-transaction: mem_req drops immediately; any later gnt/rvalid is ignored until a new request is accepted.

Optional Feature:
- Macro: LSU_MISALIGN_EN.
- Defined:
  - A misaligned access performs no bus transaction.
  - It completes through DONE with misaligned=1 and rdata=0.
- Undefined:
  - misaligned is tied 0.
  - Offending low address bits are ignored: H uses o[1] only; W uses offset 0. The access proceeds normally.

Test Plan:
- LW addr=0x100, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, done on cycle 3, rdata=0xDEADBEEF, stall high cycles 0–2.
- LB addr=0x103, mem_rdata=0x80123456 -> rdata=0xFFFFFF80; LBU same access -> rdata=0x00000080.
- SH addr=0x202, wdata=0x0000ABCD, gnt delayed 3 cycles -> mem_req and all bus fields held stable, be=1100, mem_wdata=0xABCDABCD, done one cycle after gnt.
- LW addr=0x101 with LSU_MISALIGN_EN -> no mem_req, done and misaligned=1 the cycle after accept, rdata=0; without the macro -> normal word read at 0x100.
- rst_n pulled low while in WAIT -> mem_req=0, stall=0, done=0 immediately; a later stray rvalid produces no done.
- Back-to-back SW then LHU (addr=0x2, rdata=0xF00D0000) -> second request accepted the cycle after the first DONE, rdata=0x0000F00D.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: valid/grant/rvalid data bus with lane steering and load extension.
// Optional LSU_MISALIGN_EN: misaligned accesses complete without a bus transaction.
module lsu #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [2:0]    req_size,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          misaligned,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state;

  logic [2:0]    sz_q;
  logic [1:0]    off_q;
  logic [1:0]    o;
  logic          illegal;
  logic          mis;
  logic [3:0]    be_n;
  logic [DW-1:0] wd_n;
  logic [DW-1:0] ld;
  logic [7:0]    lb;
  logic [15:0]   lh;

  assign o = addr[1:0];

  always_comb begin
    illegal = 1'b1;
    unique case (req_size)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
  end

  always_comb begin
`ifdef LSU_MISALIGN_EN
    mis = ((req_size[1:0] == 2'b01) && o[0])
       || ((req_size == 3'b010) && (o != 2'b00));
`else
    mis = 1'b0;
`endif
  end

  // Byte/half data is replicated so any enabled lane carries it.
  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    unique case (req_size[1:0])
      2'b00: begin
        be_n = 4'b0001 << o;
        wd_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_n = o[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = wdata;
      end
    endcase
  end

  always_comb begin
    lb = mem_rdata[{off_q, 3'b000} +: 8];
    lh = mem_rdata[{off_q[1], 4'b0000} +: 16];
    ld = mem_rdata;
    unique case (sz_q)
      3'b000:  ld = {{24{lb[7]}}, lb};
      3'b100:  ld = {24'd0, lb};
      3'b001:  ld = {{16{lh[15]}}, lh};
      3'b101:  ld = {16'd0, lh};
      default: ld = mem_rdata;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:      stall = req_valid & rst_n;
      REQ, WAIT: stall = 1'b1;
      default:   stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sz_q       <= 3'd0;
      off_q      <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'd0;
      mem_wdata  <= '0;
      rdata      <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            sz_q      <= req_size;
            off_q     <= o;
            mem_we    <= req_we;
            mem_addr  <= {addr[AW-1:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wd_n;
            rdata     <= '0;
            if (illegal || mis) begin
              state      <= DONE;
              done       <= 1'b1;
              misaligned <= mis & ~illegal;
            end else begin
              state      <= REQ;
              mem_req    <= 1'b1;
              misaligned <= 1'b0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata <= ld;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          done       <= 1'b0;
          misaligned <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
